parking_garage_ctrl: RTL and testbench

Multi-lane parking garage controller: tracks occupancy from per-lane entry/exit sensors, drives per-lane gates, and runs the CLOSED/OPEN/FULL/OVERRIDE operating state machine. Successor to the single-lane parking FSM, with parametrised capacity and lane count, same-cycle multi-lane arbitration, a saturating occupancy counter with error flagging, an almost-full warning and override resume. Sits between the lane sensor inputs and the gate actuators/status display logic.

---
 rtl/parking_pkg.sv | 21 ++
 rtl/parking_edge_det.sv | 24 ++
 rtl/parking_garage_ctrl.sv | 138 +++++++++++++
 tb/tb_parking_garage_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking garage controller.
// State encoding and a lane-vector population count.
package parking_pkg;

  typedef enum logic [1:0] {
    CLOSED,
    OPEN,
    FULL,
    OVERRIDE
  } pg_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/parking_edge_det.sv
// Per-bit rising-edge detector on level sensor inputs.
// History clears on reset, so a level already high counts once.
module parking_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_d;

  always_comb prev_d = d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/parking_garage_ctrl.sv
// Multi-lane garage controller: occupancy, gates, operating state.
// Exits are applied before entries so a same-cycle exit frees a space.
module parking_garage_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY  = 25,
  parameter int LANES     = 2,
  parameter int ALMOST_TH = 3,
  parameter int CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] Sense_In,
  input  logic [LANES-1:0] Sense_Out,
  input  logic             Override,
  input  logic             Start,
  input  logic             Stop,
  output logic             Open,
  output logic             Full,
  output logic             Closed,
  output logic             Override_Active,
  output logic [LANES-1:0] Gate_Up,
  output logic [CNT_W-1:0] Count,
  output logic [CNT_W-1:0] Free,
  output logic             Almost_Full,
  output logic [LANES-1:0] Reject,
  output logic             Error
);

  localparam int AW = CNT_W + 4;
  localparam logic [AW-1:0] CAP_A = AW'(CAPACITY);
  localparam logic [AW-1:0] TH_A  = AW'(ALMOST_TH);

  pg_state_e        state_q, state_d;
  logic             resume_q, resume_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0] rej_q, rej_d;
  logic             err_q, err_d;
  logic             start_q, start_d;

  logic [LANES-1:0] in_ev;
  logic [LANES-1:0] out_ev;

  parking_edge_det #(.W(LANES)) u_in_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (Sense_In),
    .rise (in_ev)
  );

  parking_edge_det #(.W(LANES)) u_out_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (Sense_Out),
    .rise (out_ev)
  );

  logic [7:0]    ov8;
  logic [AW-1:0] cnt_a, ex, ea, room, acc, cnt_n;
  logic          ex_err, in_err, acc_ok, clr;
  pg_state_e     fill;

  always_comb begin
    ov8      = '0;
    ov8[LANES-1:0] = out_ev;
    cnt_a    = AW'(cnt_q);
    ex       = AW'(popcount8(ov8));
    ex_err   = ex > cnt_a;
    ea       = ex_err ? cnt_a : ex;
    room     = CAP_A - cnt_a + ea;
    acc_ok   = state_q != CLOSED;
    acc      = '0;
    in_err   = 1'b0;
    rej_d    = '0;
    // Lowest lane wins while room remains
    for (int i = 0; i < LANES; i++) begin
      if (in_ev[i]) begin
        if (acc_ok && acc < room) acc = acc + AW'(1);
        else if (state_q == OVERRIDE) in_err = 1'b1;
        else rej_d[i] = 1'b1;
      end
    end
    cnt_n    = cnt_a - ea + acc;
    cnt_d    = cnt_n[CNT_W-1:0];
    fill     = (cnt_n < CAP_A) ? OPEN : FULL;

    state_d  = state_q;
    resume_d = resume_q;
    if (Override) begin
      state_d = OVERRIDE;
      if (state_q != OVERRIDE) resume_d = (state_q != CLOSED);
    end else if (Stop) begin
      state_d = CLOSED;
    end else if (Start) begin
      state_d = fill;
    end else begin
      unique case (state_q)
        CLOSED:     state_d = CLOSED;
        OPEN, FULL: state_d = fill;
        OVERRIDE:   state_d = resume_q ? fill : CLOSED;
      endcase
    end

    start_d  = Start;
    clr      = Start && !start_q && state_q == CLOSED;
    err_d    = (err_q && !clr) || ex_err || in_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLOSED;
      resume_q <= 1'b0;
      cnt_q    <= '0;
      rej_q    <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      cnt_q    <= cnt_d;
      rej_q    <= rej_d;
      err_q    <= err_d;
      start_q  <= start_d;
    end
  end

  assign Open            = state_q == OPEN;
  assign Full            = state_q == FULL;
  assign Closed          = state_q == CLOSED;
  assign Override_Active = state_q == OVERRIDE;
  assign Gate_Up         = {LANES{Open | Override_Active}};
  assign Count           = cnt_q;
  assign Free            = CNT_W'(CAPACITY) - cnt_q;
  assign Almost_Full     = ({4'b0000, Free} <= TH_A) && !Full;
  assign Reject          = rej_q;
  assign Error           = err_q;

endmodule

// File: tb/tb_parking_garage_ctrl.sv
// Bench for parking_garage_ctrl: car-by-car reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_parking_garage_ctrl;

  localparam int CAP = 4;
  localparam int TH  = 1;
  localparam int CL = 0, OP = 1, FU = 2, OV = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] Sense_In = '0, Sense_Out = '0;
  logic       Override = 0, Start = 0, Stop = 0;
  logic       Open, Full, Closed, Override_Active;
  logic [1:0] Gate_Up, Reject;
  logic [2:0] Count, Free;
  logic       Almost_Full, Error;

  int checks = 0;
  int failures = 0;

  parking_garage_ctrl #(
    .CAPACITY (CAP),
    .LANES    (2),
    .ALMOST_TH(TH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Sense_In       (Sense_In),
    .Sense_Out      (Sense_Out),
    .Override       (Override),
    .Start          (Start),
    .Stop           (Stop),
    .Open           (Open),
    .Full           (Full),
    .Closed         (Closed),
    .Override_Active(Override_Active),
    .Gate_Up        (Gate_Up),
    .Count          (Count),
    .Free           (Free),
    .Almost_Full    (Almost_Full),
    .Reject         (Reject),
    .Error          (Error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cars handled one at a time, exits first
  int         mst, mcnt, mres, merr;
  logic [1:0] mrej, pin, pout;
  logic       pstart;

  always @(posedge clk or posedge rst) begin : model
    int old;
    logic [1:0] ein, eout;
    if (rst) begin
      mst = CL; mcnt = 0; mres = 0; merr = 0;
      mrej = '0; pin = '0; pout = '0; pstart = 0;
    end else begin
      old  = mst;
      ein  = Sense_In & ~pin;
      eout = Sense_Out & ~pout;
      pin  = Sense_In;
      pout = Sense_Out;
      if (old == CL && Start && !pstart) merr = 0;
      pstart = Start;
      mrej = '0;
      for (int l = 0; l < 2; l++)
        if (eout[l]) begin
          if (mcnt > 0) mcnt--;
          else merr = 1;
        end
      for (int l = 0; l < 2; l++)
        if (ein[l]) begin
          if (old == CL) mrej[l] = 1;
          else if (mcnt < CAP) mcnt++;
          else if (old == OV) merr = 1;
          else mrej[l] = 1;
        end
      if (Override) begin
        if (old != OV) mres = (old != CL);
        mst = OV;
      end else if (Stop) mst = CL;
      else if (Start || old == OP || old == FU || (old == OV && mres))
        mst = (mcnt < CAP) ? OP : FU;
      else mst = CL;
    end
  end

  always @(negedge clk) begin
    chk("cmp_count", Count, mcnt);
    chk("cmp_free", Free, CAP - mcnt);
    chk("cmp_open", Open, mst == OP);
    chk("cmp_full", Full, mst == FU);
    chk("cmp_closed", Closed, mst == CL);
    chk("cmp_ovr", Override_Active, mst == OV);
    chk("cmp_gate", Gate_Up, (mst == OP || mst == OV) ? 3 : 0);
    chk("cmp_almost", Almost_Full, ((CAP - mcnt) <= TH) && mst != FU);
    chk("cmp_reject", Reject, mrej);
    chk("cmp_error", Error, merr);
  end

  task automatic cyc(input logic [1:0] i, input logic [1:0] o,
                     input logic ov, input logic st, input logic sp);
    Sense_In = i; Sense_Out = o; Override = ov; Start = st; Stop = sp;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(2'b00, 2'b00, 0, 0, 0);
  endtask

  initial begin
    #3;
    chk("rst_closed", Closed, 1);
    chk("rst_count", Count, 0);
    chk("rst_free", Free, CAP);
    chk("rst_almost", Almost_Full, 0);
    chk("rst_gate", Gate_Up, 0);
    chk("rst_error", Error, 0);
    @(negedge clk);
    rst = 0;
    cyc(2'b00, 2'b00, 0, 1, 0);
    chk("start_open", Open, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(2'b01, 2'b00, 0, 0, 0);
      chk("fill_count", Count, k);
      idle();
    end
    chk("full_flag", Full, 1);
    chk("full_gate", Gate_Up, 0);
    cyc(2'b01, 2'b00, 0, 0, 0);
    chk("fifth_reject", Reject, 2'b01);
    chk("fifth_count", Count, 4);
    idle();
    cyc(2'b10, 2'b01, 0, 0, 0);
    chk("swap_count", Count, 4);
    chk("swap_reject", Reject, 0);
    chk("swap_full", Full, 1);
    idle();
    cyc(2'b00, 2'b10, 0, 0, 0);
    chk("exit_open", Open, 1);
    idle();
    cyc(2'b11, 2'b00, 0, 0, 0);
    chk("dual_count", Count, 4);
    chk("dual_reject", Reject, 2'b10);
    chk("dual_full", Full, 1);
    idle();
    cyc(2'b00, 2'b11, 0, 0, 0);
    chk("two_out", Count, 2);
    idle();
    cyc(2'b11, 2'b01, 1, 0, 0);
    chk("ovr_active", Override_Active, 1);
    chk("ovr_gate", Gate_Up, 2'b11);
    chk("ovr_count", Count, 3);
    cyc(2'b00, 2'b00, 1, 0, 0);
    idle();
    chk("ovr_resume_open", Open, 1);
    cyc(2'b00, 2'b00, 0, 0, 1);
    chk("stop_closed", Closed, 1);
    cyc(2'b00, 2'b00, 1, 0, 0);
    chk("ovr_from_closed", Override_Active, 1);
    idle();
    chk("ovr_back_closed", Closed, 1);
    cyc(2'b00, 2'b11, 0, 0, 0);
    idle();
    cyc(2'b00, 2'b01, 0, 0, 0);
    chk("drain_zero", Count, 0);
    idle();
    cyc(2'b00, 2'b01, 0, 0, 0);
    chk("under_count", Count, 0);
    chk("under_error", Error, 1);
    idle();
    cyc(2'b00, 2'b00, 0, 1, 0);
    chk("err_clear", Error, 0);
    chk("err_clear_open", Open, 1);
    idle();
    for (int k = 0; k < 3; k++) begin
      cyc(2'b01, 2'b00, 0, 0, 0);
      idle();
    end
    chk("pre_rst_count", Count, 3);
    #3 rst = 1;
    #1;
    chk("async_closed", Closed, 1);
    chk("async_count", Count, 0);
    chk("async_free", Free, CAP);
    @(negedge clk);
    rst = 0;

    for (int n = 0; n < 3000; n++) begin
      Sense_In  = 2'($urandom_range(0, 3));
      Sense_Out = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) Override = ~Override;
      Start = ($urandom_range(0, 5) == 0);
      Stop  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1;
        #1 chk("rnd_async_count", Count, 0);
        @(negedge clk);
        rst = 0;
      end else begin
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
